// File: rtl/sfi_pipe.sv
// sfi_pipe: two-stage subtract-from-immediate unit (sfi / sfhi).
// Computes rt = sext(I10) - ra per word or halfword slot of a 128-bit register,
// carrying the target tag alongside the data and exposing a stage-1 bypass tap.
// Bit 0 is the MSB on all vector ports (SPU big-endian numbering).
module sfi_pipe (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         in_valid,
   input  logic         op_hw,
   input  logic [0:127] ra,
   input  logic [0:9]   imme,
   input  logic [0:6]   rt_addr,
   output logic         fwd1_valid,
   output logic [0:6]   fwd1_rt_addr,
   output logic [0:127] fwd1_result,
   output logic         out_valid,
   output logic [0:6]   out_rt_addr,
   output logic [0:127] result
);

   // Sign-extended immediates; imme[0] is the sign bit.
   logic [31:0]       w_s32;
   logic [15:0]       w_s16;
   logic [0:3][31:0]  w_word;
   logic [0:7][15:0]  w_half;
   logic [0:127]      w_diff;

   assign w_s32 = {{22{imme[0]}}, imme};
   assign w_s16 = {{6{imme[0]}}, imme};

   // Independent per-slot subtractors: no borrow crosses a slot boundary.
   genvar g;
   generate
      for (g = 0; g < 4; g++) begin : g_word
         assign w_word[g] = w_s32 - ra[32*g +: 32];
      end
      for (g = 0; g < 8; g++) begin : g_half
         assign w_half[g] = w_s16 - ra[16*g +: 16];
      end
   endgenerate

   assign w_diff = op_hw ? w_half : w_word;

   logic         r_s1_valid;
   logic [0:6]   r_s1_rt;
   logic [0:127] r_s1_data;
   logic         r_s2_valid;
   logic [0:6]   r_s2_rt;
   logic [0:127] r_s2_data;

   // Two register stages; flush only clears valids, data/tag always load.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_s1_rt    <= '0;
         r_s1_data  <= '0;
         r_s2_valid <= 1'b0;
         r_s2_rt    <= '0;
         r_s2_data  <= '0;
      end else begin
         r_s1_valid <= in_valid & ~flush;
         r_s1_rt    <= rt_addr;
         r_s1_data  <= w_diff;
         r_s2_valid <= r_s1_valid & ~flush;
         r_s2_rt    <= r_s1_rt;
         r_s2_data  <= r_s1_data;
      end
   end

   assign fwd1_valid   = r_s1_valid;
   assign fwd1_rt_addr = r_s1_rt;
   assign fwd1_result  = r_s1_data;
   assign out_valid    = r_s2_valid;
   assign out_rt_addr  = r_s2_rt;
   assign result       = r_s2_data;

endmodule

// File: tb/tb_sfi_pipe.sv
// tb_sfi_pipe: directed + random scoreboard bench for sfi_pipe.
module tb_sfi_pipe;

   logic         clk = 1'b0;
   logic         reset, flush, in_valid, op_hw;
   logic [127:0] ra;
   logic [9:0]   imme;
   logic [6:0]   rt_addr;
   logic         fwd1_valid, out_valid;
   logic [6:0]   fwd1_rt_addr, out_rt_addr;
   logic [127:0] fwd1_result, result;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      int           due;
      logic [6:0]   rt;
      logic [127:0] data;
   } ent_t;
   ent_t q[$];

   always #5 clk = ~clk;

   sfi_pipe dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
      .op_hw(op_hw), .ra(ra), .imme(imme), .rt_addr(rt_addr),
      .fwd1_valid(fwd1_valid), .fwd1_rt_addr(fwd1_rt_addr),
      .fwd1_result(fwd1_result), .out_valid(out_valid),
      .out_rt_addr(out_rt_addr), .result(result)
   );

   // Reference: word 0 sits in bits [127:96] of a descending vector.
   function automatic logic [127:0] model(input bit hw, input logic [9:0] imm,
                                          input logic [127:0] a);
      logic [127:0] r;
      logic [31:0]  s32;
      logic [15:0]  s16;
      s32 = {{22{imm[9]}}, imm};
      s16 = {{6{imm[9]}}, imm};
      r = '0;
      if (hw) begin
         for (int h = 0; h < 8; h++) r[127-16*h -: 16] = s16 - a[127-16*h -: 16];
      end else begin
         for (int w = 0; w < 4; w++) r[127-32*w -: 32] = s32 - a[127-32*w -: 32];
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Drive one cycle, update scoreboard, clock, then check both taps.
   task automatic step(input bit iv, input bit hw, input logic [9:0] imm,
                       input logic [127:0] a, input logic [6:0] rt,
                       input logic [127:0] exp, input bit fl, input bit rst);
      int fi;
      in_valid = iv; op_hw = hw; imme = imm; ra = a; rt_addr = rt;
      flush = fl; reset = rst;
      if (rst) q.delete();
      else begin
         if (fl)
            for (int i = q.size() - 1; i >= 0; i--)
               if (q[i].due == cyc + 1) q.delete(i);
         if (iv && !fl) q.push_back('{cyc + 2, rt, exp});
      end
      @(posedge clk);
      cyc++;
      #1;
      while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
      if (q.size() > 0 && q[0].due == cyc) begin
         chk("out_valid", {127'd0, out_valid}, 128'd1);
         chk("out_rt", {121'd0, out_rt_addr}, {121'd0, q[0].rt});
         chk("result", result, q[0].data);
         void'(q.pop_front());
      end else begin
         chk("out_valid_idle", {127'd0, out_valid}, 128'd0);
      end
      fi = -1;
      foreach (q[i]) if (q[i].due == cyc + 1) fi = i;
      if (fi >= 0) begin
         chk("fwd1_valid", {127'd0, fwd1_valid}, 128'd1);
         chk("fwd1_rt", {121'd0, fwd1_rt_addr}, {121'd0, q[fi].rt});
         chk("fwd1_result", fwd1_result, q[fi].data);
      end else begin
         chk("fwd1_valid_idle", {127'd0, fwd1_valid}, 128'd0);
      end
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 10'h0, 128'h0, 7'd0, 128'h0, 1'b0, 1'b0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_fv"}, {127'd0, fwd1_valid}, 128'd0);
      chk({tag, "_frt"}, {121'd0, fwd1_rt_addr}, 128'd0);
      chk({tag, "_fres"}, fwd1_result, 128'd0);
      chk({tag, "_ov"}, {127'd0, out_valid}, 128'd0);
      chk({tag, "_ort"}, {121'd0, out_rt_addr}, 128'd0);
      chk({tag, "_res"}, result, 128'd0);
   endtask

   initial begin
      logic [127:0] a, e;
      bit hw;
      logic [9:0] im;
      // Reset state
      step(1'b1, 1'b0, 10'h3FF, {4{32'h5}}, 7'd9, 128'h0, 1'b0, 1'b1);
      chk_zero("reset");
      step(1'b0, 1'b0, 10'h0, 128'h0, 7'd0, 128'h0, 1'b0, 1'b1);
      chk_zero("reset2");

      // Word basic
      step(1'b1, 1'b0, 10'h00A, {4{32'h3}}, 7'd1, {4{32'h7}}, 1'b0, 1'b0);
      idle(); idle();
      // Word negative immediate / wrap
      step(1'b1, 1'b0, 10'h200,
           {32'h7FFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h80000000}, 7'd2,
           {32'h7FFFFE01, 32'hFFFFFE00, 32'hFFFFFE01, 32'h7FFFFE00}, 1'b0, 1'b0);
      idle(); idle();
      // Halfword, then same ra in word mode to show slot isolation
      step(1'b1, 1'b1, 10'h1FF, {8{16'h0200}}, 7'd3, {8{16'hFFFF}}, 1'b0, 1'b0);
      step(1'b1, 1'b0, 10'h1FF, {8{16'h0200}}, 7'd4, {4{32'hFDFFFFFF}}, 1'b0, 1'b0);
      idle(); idle();
      // Back-to-back mixed modes
      step(1'b1, 1'b0, 10'h3FF, {4{32'h5}}, 7'd10, {4{32'hFFFFFFFA}}, 1'b0, 1'b0);
      step(1'b1, 1'b1, 10'h001, {8{16'h1}}, 7'd11, 128'h0, 1'b0, 1'b0);
      idle();
      step(1'b1, 1'b0, 10'h000, {4{32'h1}}, 7'd12, {4{32'hFFFFFFFF}}, 1'b0, 1'b0);
      idle(); idle();
      // Flush: A survives, B (in S1) and C (incoming) are dropped
      step(1'b1, 1'b0, 10'h004, {4{32'h1}}, 7'd20, {4{32'h3}}, 1'b0, 1'b0);
      step(1'b1, 1'b0, 10'h005, {4{32'h1}}, 7'd21, {4{32'h4}}, 1'b0, 1'b0);
      step(1'b1, 1'b0, 10'h006, {4{32'h1}}, 7'd22, {4{32'h5}}, 1'b1, 1'b0);
      idle(); idle();
      // Flush with nothing in flight
      step(1'b0, 1'b0, 10'h0, 128'h0, 7'd0, 128'h0, 1'b1, 1'b0);
      // Reset mid-stream with two ops in flight
      step(1'b1, 1'b0, 10'h010, {4{32'h2}}, 7'd30, {4{32'hE}}, 1'b0, 1'b0);
      step(1'b1, 1'b1, 10'h010, {8{16'h2}}, 7'd31, {8{16'hE}}, 1'b0, 1'b0);
      step(1'b1, 1'b0, 10'h001, {4{32'h1}}, 7'd32, 128'h0, 1'b0, 1'b1);
      chk_zero("midreset");
      step(1'b1, 1'b0, 10'h008, {4{32'h3}}, 7'd33, {4{32'h5}}, 1'b0, 1'b0);
      idle(); idle();
      // Random mixed traffic with occasional flushes
      for (int n = 0; n < 60; n++) begin
         a  = {$urandom, $urandom, $urandom, $urandom};
         im = 10'($urandom);
         hw = 1'($urandom);
         e  = model(hw, im, a);
         step(($urandom_range(3) != 0), hw, im, a, 7'($urandom), e,
              ($urandom_range(9) == 0), 1'b0);
      end
      idle(); idle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      failures++;
      $display("FAIL timeout got=running exp=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sfi_pipe.md
# sfi_pipe

Pipelined subtract-from-immediate unit for the FX1 simple-fixed execution group. It computes `sfi` (word: `rt = sext32(I10) - ra`) and `sfhi` (halfword: `rt = sext16(I10) - ra`) across all 128-bit slots. This is the reverse-operand counterpart of the add-immediate path. The unit is two register stages deep, carries the target register tag alongside the data, supports pipeline flush, and exposes per-stage forwarding taps for the register-file bypass network.

## Interface

- No parameters; widths are fixed by the SPU ISA.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  kill all in-flight and incoming operations this cycle.
- `in_valid`  in  1  operation present on the inputs.
- `op_hw`  in  1  0 = `sfi` (word), 1 = `sfhi` (halfword).
- `ra`  in  [0:127]  source register; bit 0 is the MSB.
- `imme`  in  [0:9]  I10 immediate; `imme[0]` is the sign bit.
- `rt_addr`  in  [0:6]  target register number.
- `fwd1_valid`, `fwd1_rt_addr[0:6]`, `fwd1_result[0:127]`  out  stage-1 bypass tap.
- `out_valid`  out  1  stage-2 result valid (write-back request).
- `out_rt_addr`  out  [0:6]  target register for write-back.
- `result`  out  [0:127]  final result.

## Operation

- Immediate extension:
  - Word mode: `s32 = {22{imme[0]}, imme}`.
  - Halfword mode: `s16 = {6{imme[0]}, imme}`.
- Word mode:
  - For each slot w = 0..3, `result[32w:32w+31] = s32 - ra[32w:32w+31]`, modulo 2^32.
  - No carry or borrow crosses a word boundary.
  - No overflow or exception flag is produced.
- Halfword mode:
  - For each h = 0..7, `result[16h:16h+15] = s16 - ra[16h:16h+15]`, modulo 2^16.
  - No borrow crosses a halfword boundary.
- Stage 1 (S1):
  - On each edge, register `in_valid & ~flush`, `rt_addr`, and the computed difference.
  - When the captured valid is 0, data and tag registers still load; consumers must gate on valid.
- Stage 2 (S2):
  - On each edge, register `S1.valid & ~flush` along with the S1 data and tag.
- Output mapping:
  - `fwd1_*` is driven directly from the S1 registers.
  - `out_*` and `result` are driven directly from the S2 registers.
  - There is no combinational path from inputs to outputs.
- Flush:
  - When asserted at edge k, the S1 and S2 valids both load 0, and the operation on the inputs at edge k is dropped.
  - Flush affects only the valid bits; data and tag registers behave as normal.
- Reset:
  - When asserted at edge k, all valids and all data and tag registers load 0.
  - Reset has priority over flush and `in_valid`.
  - Operations in flight during reset are lost; no partial result is emitted.
- The unit never stalls and has no ready signal; back-to-back issue every cycle is supported.

## Timing

- Latency is 2 cycles:
  - An operation sampled at rising edge k appears on `fwd1_*` after edge k and on `out_*` after edge k+1.
  - `out_valid` is high for exactly one cycle per accepted operation.
- Throughput is 1 operation per cycle.
- Reset values (after any edge with `reset`=1):
  - `fwd1_valid`=0, `fwd1_rt_addr`=0, `fwd1_result`=0.
  - `out_valid`=0, `out_rt_addr`=0, `result`=0.
- Simultaneous `in_valid` and `flush` at edge k:
  - The operation is dropped.
  - The operation then in S1 does not reach S2 valid.
- `flush` with no operation in flight is harmless: all valids are already 0.
- `op_hw` and `imme` are sampled only at the edge where `in_valid` is high; each operation uses its own mode independently of its pipeline neighbours.

## Test plan

- Word basic: `sfi`, `imme`=0x00A, all `ra` words 0x00000003. Expect `out_valid`=1 two edges later, every word of `result` = 0x00000007, and `fwd1_result` equal to the same value one edge earlier.
- Word negative imm / wrap: `imme`=0x200 (−512), `ra` words {0x7FFFFFFF, 0x00000000, 0xFFFFFFFF, 0x80000000}. Expect `result` {0x7FFFFE01, 0xFFFFFE00, 0xFFFFFE01, 0x7FFFFE00}.
- Halfword: `sfhi`, `imme`=0x1FF (511), all `ra` halfwords 0x0200. Expect every halfword = 0xFFFF, and no borrow leaks into the neighbouring halfword (compare against a word-mode result for the same `ra`).
- Back-to-back with mixed modes over 4 cycles: issue `sfi` (`imme`=0x3FF, `ra` words=5, `rt`=10), `sfhi` (`imme`=0x001, `ra` halfwords=1, `rt`=11), an idle cycle, then `sfi` (`imme`=0, `ra` words=1, `rt`=12). Expect, in order on consecutive cycles:
  - `rt`=10 with words 0xFFFFFFFA;
  - `rt`=11 with all zeros;
  - an idle cycle with `out_valid`=0;
  - `rt`=12 with words 0xFFFFFFFF.
- Flush: issue ops A, B, C on consecutive edges, with `flush` high on the edge that samples C. Expect A to write back, and B and C never to assert `out_valid` or `fwd1_valid` thereafter.
- Reset mid-stream: with two ops in flight, assert `reset` for one edge. Expect all outputs to be 0 after that edge and no write-back of the in-flight ops. An op issued on the next edge completes normally 2 edges later.
